// File: rtl/bsg_link_ddr_downstream_sipo_if.sv
// ----------------------------------------------------------------------------
// bsg_link_ddr_downstream_sipo_if
//   Bundles the link-side beat inputs and the core-side FIFO/credit outputs of
//   bsg_link_ddr_downstream_sipo.
//   master : link/consumer side (drives io_valid_i, io_data_i, core_yumi_i)
//   slave  : the downstream SIPO itself
//   Signals:
//     io_valid_i   [NUM_CHANNELS]  per-channel beat valid
//     io_data_i    [BW]            channel c at [c*CHANNEL_WIDTH +: CHANNEL_WIDTH]
//     core_valid_o                 FIFO head valid
//     core_data_o  [WIDTH]         FIFO head word
//     core_yumi_i                  consume head (only meaningful with core_valid_o)
//     token_o                      credit token
//     overflow_o                   sticky overflow flag
//     skew_err_o                   sticky channel-skew flag
//     words_rcvd_o [16]            pushed-word count (only with BSG_LINK_DS_WORD_CNT_EN)
//   Handshake: a word leaves the FIFO on every rising clk edge where
//   core_valid_o && core_yumi_i; core_yumi_i while core_valid_o=0 has no effect.
//   Beats carry no backpressure: a beat is taken on every edge where all bits
//   of io_valid_i are set.
// ----------------------------------------------------------------------------
interface bsg_link_ddr_downstream_sipo_if #(
    parameter int CHANNEL_WIDTH = 8,
    parameter int NUM_CHANNELS  = 2,
    parameter int WIDTH         = 64
);
    logic [NUM_CHANNELS-1:0]               io_valid_i;
    logic [NUM_CHANNELS*CHANNEL_WIDTH-1:0] io_data_i;
    logic                                  core_valid_o;
    logic [WIDTH-1:0]                      core_data_o;
    logic                                  core_yumi_i;
    logic                                  token_o;
    logic                                  overflow_o;
    logic                                  skew_err_o;
`ifdef BSG_LINK_DS_WORD_CNT_EN
    logic [15:0]                           words_rcvd_o;
`endif

    modport master (
        output io_valid_i, io_data_i, core_yumi_i,
        input  core_valid_o, core_data_o, token_o, overflow_o, skew_err_o
`ifdef BSG_LINK_DS_WORD_CNT_EN
        , words_rcvd_o
`endif
    );

    modport slave (
        input  io_valid_i, io_data_i, core_yumi_i,
        output core_valid_o, core_data_o, token_o, overflow_o, skew_err_o
`ifdef BSG_LINK_DS_WORD_CNT_EN
        , words_rcvd_o
`endif
    );
endinterface

// File: rtl/bsg_link_ddr_downstream_sipo.sv
// ----------------------------------------------------------------------------
// bsg_link_ddr_downstream_sipo
//   Receive side of the DDR link: gathers BEATS lockstep beats into a WIDTH-bit
//   word (beat 0 in the LSBs), queues words in a FIFO_ELS-deep FIFO and returns
//   credits by toggling token_o once every TOKEN_DECIMATION pops.
//   Ports:
//     clk    clock
//     rst_n  asynchronous active-low reset
//     link   bsg_link_ddr_downstream_sipo_if.slave (beats in, FIFO head/flags out)
//   Optional build macro BSG_LINK_DS_WORD_CNT_EN adds words_rcvd_o, a 16-bit
//   wrapping count of words actually written into the FIFO.
// ----------------------------------------------------------------------------
module bsg_link_ddr_downstream_sipo #(
    parameter int CHANNEL_WIDTH    = 8,
    parameter int NUM_CHANNELS     = 2,
    parameter int WIDTH            = 64,
    parameter int FIFO_ELS         = 4,
    parameter int TOKEN_DECIMATION = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    bsg_link_ddr_downstream_sipo_if.slave     link
);
    localparam int BW    = NUM_CHANNELS * CHANNEL_WIDTH;
    localparam int BEATS = WIDTH / BW;
    localparam int CTR_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PTR_W = (FIFO_ELS > 1) ? $clog2(FIFO_ELS) : 1;
    localparam int TOK_W = (TOKEN_DECIMATION > 1) ? $clog2(TOKEN_DECIMATION) : 1;

    logic [CTR_W-1:0] beat_ctr;
    logic [WIDTH-1:0] asm_r;
    logic [WIDTH-1:0] word_next;
    logic [WIDTH-1:0] mem [FIFO_ELS];
    // One extra wrap bit on each pointer distinguishes full from empty.
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic [TOK_W-1:0] tok_ctr;
    logic             token_r;
    logic             overflow_r;
    logic             skew_r;

    logic beat_all, beat_skew, last_beat, empty, full, pop, push_ok;

    assign beat_all  = &link.io_valid_i;
    assign beat_skew = (|link.io_valid_i) & ~beat_all;
    assign last_beat = beat_all && (beat_ctr == CTR_W'(BEATS - 1));
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                       (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign pop       = ~empty & link.core_yumi_i;
    // A pop in the same cycle frees the slot the push is about to use.
    assign push_ok   = last_beat && (~full || pop);

    // Assembly register with the current beat merged in; on the last beat this
    // is the complete word pushed into the FIFO.
    always_comb begin
        word_next = asm_r;
        word_next[beat_ctr*BW +: BW] = link.io_data_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_ctr <= '0;
            asm_r    <= '0;
            skew_r   <= 1'b0;
        end else if (beat_all) begin
            asm_r    <= word_next;
            beat_ctr <= last_beat ? '0 : beat_ctr + 1'b1;
        end else if (beat_skew) begin
            skew_r   <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_ELS; i++) mem[i] <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            overflow_r <= 1'b0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr[PTR_W-1:0]] <= word_next;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (last_beat && full && !pop) overflow_r <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tok_ctr <= '0;
            token_r <= 1'b0;
        end else if (pop) begin
            if (tok_ctr == TOK_W'(TOKEN_DECIMATION - 1)) begin
                tok_ctr <= '0;
                token_r <= ~token_r;
            end else begin
                tok_ctr <= tok_ctr + 1'b1;
            end
        end
    end

`ifdef BSG_LINK_DS_WORD_CNT_EN
    logic [15:0] words_rcvd_r;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       words_rcvd_r <= '0;
        else if (push_ok) words_rcvd_r <= words_rcvd_r + 16'd1;
    end
    assign link.words_rcvd_o = words_rcvd_r;
`endif

    assign link.core_valid_o = ~empty;
    assign link.core_data_o  = mem[rd_ptr[PTR_W-1:0]];
    assign link.token_o      = token_r;
    assign link.overflow_o   = overflow_r;
    assign link.skew_err_o   = skew_r;
endmodule

// File: tb/tb_bsg_link_ddr_downstream_sipo.sv
// ----------------------------------------------------------------------------
// tb_bsg_link_ddr_downstream_sipo
//   Directed bench for bsg_link_ddr_downstream_sipo (default parameters:
//   2 channels x 8 bits, 64-bit words, 4-deep FIFO, token every 4 pops).
//   Inputs change 1ns after the rising edge; outputs are sampled there too.
// ----------------------------------------------------------------------------
module tb_bsg_link_ddr_downstream_sipo;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    bsg_link_ddr_downstream_sipo_if #(.CHANNEL_WIDTH(8), .NUM_CHANNELS(2), .WIDTH(64)) link ();

    bsg_link_ddr_downstream_sipo #(
        .CHANNEL_WIDTH(8), .NUM_CHANNELS(2), .WIDTH(64),
        .FIFO_ELS(4), .TOKEN_DECIMATION(4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .link  (link.slave)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic reset_dut();
        link.io_valid_i  = 2'b00;
        link.io_data_i   = 16'h0000;
        link.core_yumi_i = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // ---------------- drivers ----------------
    task automatic send_beat(input logic [15:0] d);
        link.io_valid_i = 2'b11;
        link.io_data_i  = d;
        @(posedge clk);
        #1;
    endtask

    // hold=1 leaves io_valid_i asserted so the next word can follow directly.
    task automatic send_word(input logic [63:0] w, input bit hold);
        for (int b = 0; b < 4; b++) send_beat(w[b*16 +: 16]);
        if (!hold) link.io_valid_i = 2'b00;
    endtask

    task automatic pop_one();
        link.core_yumi_i = 1'b1;
        @(posedge clk);
        #1;
        link.core_yumi_i = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_dut();
        checks++; if (link.core_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", link.core_valid_o); end
        checks++; if (link.core_data_o !== 64'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", link.core_data_o); end
        checks++; if (link.token_o !== 1'b0) begin errors++; $display("FAIL reset_token: got %b expected 0", link.token_o); end
        checks++; if (link.overflow_o !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", link.overflow_o); end
        checks++; if (link.skew_err_o !== 1'b0) begin errors++; $display("FAIL reset_skew: got %b expected 0", link.skew_err_o); end
        // Asynchronous assertion: state must clear without any clock edge.
        send_word(64'hCAFE_F00D_1234_5678, 0);
        checks++; if (link.core_valid_o !== 1'b1) begin errors++; $display("FAIL pre_async_valid: got %b expected 1", link.core_valid_o); end
        rst_n = 1'b0;
        #2;
        checks++; if (link.core_valid_o !== 1'b0) begin errors++; $display("FAIL async_reset_valid: got %b expected 0", link.core_valid_o); end
        checks++; if (link.core_data_o !== 64'h0) begin errors++; $display("FAIL async_reset_data: got %h expected 0", link.core_data_o); end
`ifdef BSG_LINK_DS_WORD_CNT_EN
        checks++; if (link.words_rcvd_o !== 16'd0) begin errors++; $display("FAIL async_reset_cnt: got %0d expected 0", link.words_rcvd_o); end
`endif
    endtask

    task automatic test_basic_word();
        reset_dut();
        send_word(64'h8877665544332211, 0);
        checks++; if (link.core_valid_o !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", link.core_valid_o); end
        checks++; if (link.core_data_o !== 64'h8877665544332211) begin errors++; $display("FAIL basic_data: got %h expected 8877665544332211", link.core_data_o); end
        pop_one();
        checks++; if (link.core_valid_o !== 1'b0) begin errors++; $display("FAIL basic_empty: got %b expected 0", link.core_valid_o); end
    endtask

    task automatic test_overflow();
        logic [63:0] w [5];
        w[0] = 64'h0000_0000_0000_0A0A; w[1] = 64'h1111_2222_3333_4444;
        w[2] = 64'hFFFF_0000_FFFF_0000; w[3] = 64'h0123_4567_89AB_CDEF;
        w[4] = 64'hDEAD_BEEF_DEAD_BEEF;
        reset_dut();
        for (int i = 0; i < 4; i++) send_word(w[i], 0);
        checks++; if (link.overflow_o !== 1'b0) begin errors++; $display("FAIL ovf_before: got %b expected 0", link.overflow_o); end
        send_word(w[4], 0);
        checks++; if (link.overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", link.overflow_o); end
        checks++; if (link.core_data_o !== w[0]) begin errors++; $display("FAIL ovf_head: got %h expected %h", link.core_data_o, w[0]); end
`ifdef BSG_LINK_DS_WORD_CNT_EN
        checks++; if (link.words_rcvd_o !== 16'd4) begin errors++; $display("FAIL ovf_cnt: got %0d expected 4", link.words_rcvd_o); end
`endif
        for (int i = 0; i < 4; i++) begin
            checks++; if (link.core_valid_o !== 1'b1 || link.core_data_o !== w[i]) begin errors++; $display("FAIL ovf_pop%0d: got v=%b %h expected v=1 %h", i, link.core_valid_o, link.core_data_o, w[i]); end
            pop_one();
        end
        checks++; if (link.core_valid_o !== 1'b0) begin errors++; $display("FAIL ovf_drained: got %b expected 0", link.core_valid_o); end
        checks++; if (link.overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", link.overflow_o); end
    endtask

    task automatic test_full_with_pop();
        logic [63:0] w [5];
        w[0] = 64'h1000_0000_0000_0001; w[1] = 64'h2000_0000_0000_0002;
        w[2] = 64'h3000_0000_0000_0003; w[3] = 64'h4000_0000_0000_0004;
        w[4] = 64'h5555_AAAA_5555_AAAA;
        reset_dut();
        for (int i = 0; i < 4; i++) send_word(w[i], 0);
        for (int b = 0; b < 3; b++) send_beat(w[4][b*16 +: 16]);
        // Last beat and pop land on the same edge.
        link.io_valid_i  = 2'b11;
        link.io_data_i   = w[4][63:48];
        link.core_yumi_i = 1'b1;
        @(posedge clk);
        #1;
        link.core_yumi_i = 1'b0;
        link.io_valid_i  = 2'b00;
        checks++; if (link.overflow_o !== 1'b0) begin errors++; $display("FAIL fullpop_ovf: got %b expected 0", link.overflow_o); end
        for (int i = 1; i < 5; i++) begin
            checks++; if (link.core_valid_o !== 1'b1 || link.core_data_o !== w[i]) begin errors++; $display("FAIL fullpop_pop%0d: got v=%b %h expected v=1 %h", i, link.core_valid_o, link.core_data_o, w[i]); end
            pop_one();
        end
        checks++; if (link.core_valid_o !== 1'b0) begin errors++; $display("FAIL fullpop_drained: got %b expected 0", link.core_valid_o); end
`ifdef BSG_LINK_DS_WORD_CNT_EN
        checks++; if (link.words_rcvd_o !== 16'd5) begin errors++; $display("FAIL fullpop_cnt: got %0d expected 5", link.words_rcvd_o); end
`endif
    endtask

    task automatic test_skew();
        logic [63:0] w;
        w = 64'hA1B2_C3D4_E5F6_0718;
        reset_dut();
        send_beat(w[15:0]);
        link.io_valid_i = 2'b00;   // idle gap is not skew
        @(posedge clk);
        #1;
        checks++; if (link.skew_err_o !== 1'b0) begin errors++; $display("FAIL skew_idle: got %b expected 0", link.skew_err_o); end
        send_beat(w[31:16]);
        link.io_valid_i = 2'b01;
        link.io_data_i  = 16'hBAD0;
        @(posedge clk);
        #1;
        link.io_valid_i = 2'b10;
        link.io_data_i  = 16'hBAD1;
        @(posedge clk);
        #1;
        checks++; if (link.skew_err_o !== 1'b1) begin errors++; $display("FAIL skew_set: got %b expected 1", link.skew_err_o); end
        checks++; if (link.core_valid_o !== 1'b0) begin errors++; $display("FAIL skew_no_word: got %b expected 0", link.core_valid_o); end
        send_beat(w[47:32]);
        send_beat(w[63:48]);
        link.io_valid_i = 2'b00;
        checks++; if (link.core_valid_o !== 1'b1 || link.core_data_o !== w) begin errors++; $display("FAIL skew_word: got v=%b %h expected v=1 %h", link.core_valid_o, link.core_data_o, w); end
        checks++; if (link.skew_err_o !== 1'b1) begin errors++; $display("FAIL skew_sticky: got %b expected 1", link.skew_err_o); end
    endtask

    task automatic test_token();
        logic exp_tok;
        reset_dut();
        // yumi on an empty FIFO must not advance the pop counter.
        link.core_yumi_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        link.core_yumi_i = 1'b0;
        checks++; if (link.token_o !== 1'b0) begin errors++; $display("FAIL tok_empty_yumi: got %b expected 0", link.token_o); end
        for (int k = 1; k <= 8; k++) begin
            send_word(64'(k) * 64'h0101_0101_0101_0101, 0);
            pop_one();
            exp_tok = (k >= 4 && k < 8) ? 1'b1 : 1'b0;
            checks++; if (link.token_o !== exp_tok) begin errors++; $display("FAIL tok_pop%0d: got %b expected %b", k, link.token_o, exp_tok); end
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] a, b;
        a = 64'h0F0E_0D0C_0B0A_0908;
        b = 64'h7766_5544_3322_1100;
        reset_dut();
        send_word(a, 1);
        send_word(b, 0);
        checks++; if (link.core_data_o !== a) begin errors++; $display("FAIL b2b_first: got %h expected %h", link.core_data_o, a); end
        pop_one();
        checks++; if (link.core_valid_o !== 1'b1 || link.core_data_o !== b) begin errors++; $display("FAIL b2b_second: got v=%b %h expected v=1 %h", link.core_valid_o, link.core_data_o, b); end
        pop_one();
        checks++; if (link.core_valid_o !== 1'b0) begin errors++; $display("FAIL b2b_drained: got %b expected 0", link.core_valid_o); end
    endtask

    task automatic test_reset_mid_word();
        logic [63:0] f;
        f = 64'h1357_9BDF_2468_ACE0;
        reset_dut();
        send_beat(16'hEEEE);
        send_beat(16'hDDDD);
        link.io_valid_i = 2'b00;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_word(f, 0);
        checks++; if (link.core_valid_o !== 1'b1 || link.core_data_o !== f) begin errors++; $display("FAIL rstmid_word: got v=%b %h expected v=1 %h", link.core_valid_o, link.core_data_o, f); end
`ifdef BSG_LINK_DS_WORD_CNT_EN
        checks++; if (link.words_rcvd_o !== 16'd1) begin errors++; $display("FAIL rstmid_cnt: got %0d expected 1", link.words_rcvd_o); end
`endif
        pop_one();
        checks++; if (link.core_valid_o !== 1'b0) begin errors++; $display("FAIL rstmid_single: got %b expected 0", link.core_valid_o); end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b1;
        link.io_valid_i  = 2'b00;
        link.io_data_i   = 16'h0000;
        link.core_yumi_i = 1'b0;
        test_reset();
        test_basic_word();
        test_overflow();
        test_full_with_pop();
        test_skew();
        test_token();
        test_back_to_back();
        test_reset_mid_word();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
